// File: rtl/multiport_register_file_pkg.sv
// register_file_pkg: shared defaults, flags register address and flag bit indices
package register_file_pkg;
  localparam int DEF_L = 16;
  localparam int DEF_A = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  function automatic int FLAGS_ADDR(input int a);
    return (1 << a) - 1;
  endfunction
endpackage

// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: read/write/flags/reservation/debug bundle between decode, write-back and the file
interface multiport_register_file_if #(
  parameter int L = register_file_pkg::DEF_L,
  parameter int A = register_file_pkg::DEF_A,
  parameter int NR = 2
);
  localparam int R = 2**A;
  logic [NR*A-1:0] RdAddr;
  logic [NR*L-1:0] RdData;
  logic [NR-1:0] RdBusy;
  logic We0;
  logic [A-1:0] WAddr0;
  logic [L-1:0] WData0;
  logic We1;
  logic [A-1:0] WAddr1;
  logic [L-1:0] WData1;
  logic [L-1:0] FlagsMask;
  logic [L-1:0] FlagsIn;
  logic [L-1:0] FlagsOut;
  logic ResvEn;
  logic [A-1:0] ResvAddr;
  logic [L*R-1:0] DebugData;
  logic [R-1:0] DebugBusy;
  modport master (
    output RdAddr, We0, WAddr0, WData0, We1, WAddr1, WData1, FlagsMask, FlagsIn, ResvEn, ResvAddr,
    input RdData, RdBusy, FlagsOut, DebugData, DebugBusy
  );
  modport slave (
    input RdAddr, We0, WAddr0, WData0, We1, WAddr1, WData1, FlagsMask, FlagsIn, ResvEn, ResvAddr,
    output RdData, RdBusy, FlagsOut, DebugData, DebugBusy
  );
endinterface

// File: rtl/multiport_register_file_scoreboard.sv
// rf_scoreboard: per-register busy bits, reserve-over-release priority, busy read ports
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int A = DEF_A,
  parameter int NR = 2
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              ResvEn,
  input  logic [A-1:0]      ResvAddr,
  input  logic              We0,
  input  logic [A-1:0]      WAddr0,
  input  logic              We1,
  input  logic [A-1:0]      WAddr1,
  input  logic [NR*A-1:0]   RdAddr,
  input  logic [NR-1:0]     Fwd,
  output logic [NR-1:0]     RdBusy,
  output logic [2**A-1:0]   DebugBusy
);
  localparam int R = 2**A;
  logic [R-1:0] busy;
  logic [R-1:0] setMask;
  logic [R-1:0] clrMask;
  assign setMask = ResvEn ? R'(1) << ResvAddr : '0;
  assign clrMask = (We0 ? R'(1) << WAddr0 : '0) | (We1 ? R'(1) << WAddr1 : '0);
  // Release on write-back, but a same-cycle reservation is a new producer and wins.
  always_ff @(posedge Clk or negedge ResetN)
    if (!ResetN) busy <= '0;
    else busy <= (busy & ~clrMask) | setMask;
  for (genvar k = 0; k < NR; k++) begin : gBusy
    assign RdBusy[k] = busy[RdAddr[k*A +: A]] & ~Fwd[k];
  end
  assign DebugBusy = busy;
endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: R x L registers, NR read ports, two prioritised writes, masked flags, busy scoreboard
module multiport_register_file
  import register_file_pkg::*;
#(
  parameter int L = DEF_L,
  parameter int A = DEF_A,
  parameter int NR = 2,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b0
) (
  input logic Clk,
  input logic ResetN,
  multiport_register_file_if.slave bus
);
  localparam int R = 2**A;
  localparam logic [A-1:0] FlagsAddr = A'(FLAGS_ADDR(A));
  logic [R-1:0][L-1:0] data;
  logic we0;
  logic we1;
  logic resv;
  logic [L-1:0] flagsNext;
  logic [NR-1:0] fwd;
  // With a hard-wired zero register, anything aimed at r0 is dropped here once for everyone.
  assign we0 = bus.We0 && !(ZERO_REG && bus.WAddr0 == '0);
  assign we1 = bus.We1 && !(ZERO_REG && bus.WAddr1 == '0);
  assign resv = bus.ResvEn && !(ZERO_REG && bus.ResvAddr == '0);
  assign flagsNext = (data[FlagsAddr] & ~bus.FlagsMask) | (bus.FlagsIn & bus.FlagsMask);
  for (genvar i = 0; i < R; i++) begin : gReg
    if (ZERO_REG && i == 0) begin : gZero
      assign data[i] = '0;
    end else begin : gStore
      logic hit0;
      logic hit1;
      logic [L-1:0] q;
      assign hit0 = we0 && bus.WAddr0 == A'(i);
      assign hit1 = we1 && bus.WAddr1 == A'(i);
      // Port 1 beats port 0; the flags merge applies only when neither port writes this register.
      always_ff @(posedge Clk or negedge ResetN)
        if (!ResetN) q <= '0;
        else if (hit1) q <= bus.WData1;
        else if (hit0) q <= bus.WData0;
        else if (A'(i) == FlagsAddr) q <= flagsNext;
      assign data[i] = q;
    end
  end
  for (genvar k = 0; k < NR; k++) begin : gRd
    logic [A-1:0] ra;
    logic f0;
    logic f1;
    assign ra = bus.RdAddr[k*A +: A];
    assign f1 = BYPASS && we1 && bus.WAddr1 == ra;
    assign f0 = BYPASS && we0 && bus.WAddr0 == ra;
    assign fwd[k] = f0 | f1;
    assign bus.RdData[k*L +: L] = f1 ? bus.WData1 : f0 ? bus.WData0 : data[ra];
  end
  for (genvar i = 0; i < R; i++) begin : gDbg
    assign bus.DebugData[i*L +: L] = data[i];
  end
  assign bus.FlagsOut = data[FlagsAddr];
  rf_scoreboard #(.A(A), .NR(NR)) uScoreboard (
    .Clk(Clk),
    .ResetN(ResetN),
    .ResvEn(resv),
    .ResvAddr(bus.ResvAddr),
    .We0(we0),
    .WAddr0(bus.WAddr0),
    .We1(we1),
    .WAddr1(bus.WAddr1),
    .RdAddr(bus.RdAddr),
    .Fwd(fwd),
    .RdBusy(bus.RdBusy),
    .DebugBusy(bus.DebugBusy)
  );
endmodule

// File: tb/tb_multiport_register_file.sv
// tb_multiport_register_file: directed vectors against a plain instance and a bypass+zero-register instance
module tb_multiport_register_file;
  typedef struct {
    logic we0; logic [2:0] wa0; logic [15:0] wd0;
    logic we1; logic [2:0] wa1; logic [15:0] wd1;
    logic [15:0] fm; logic [15:0] fi;
    logic re; logic [2:0] ra;
    logic [2:0] a0; logic [2:0] a1;
    logic [15:0] aRd0; logic [15:0] aRd1; logic [1:0] aBs;
    logic [15:0] bRd0; logic [15:0] bRd1; logic [1:0] bBs;
    logic [15:0] fl;
  } vec_t;
  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t v[18];
  vec_t idle;
  multiport_register_file_if #(.L(16), .A(3), .NR(2)) busA ();
  multiport_register_file_if #(.L(16), .A(3), .NR(2)) busB ();
  multiport_register_file #(.L(16), .A(3), .NR(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutA (
    .Clk(Clk), .ResetN(ResetN), .bus(busA.slave));
  multiport_register_file #(.L(16), .A(3), .NR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutB (
    .Clk(Clk), .ResetN(ResetN), .bus(busB.slave));
  always #5 Clk = ~Clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic apply(input vec_t x);
    busA.We0 = x.we0; busA.WAddr0 = x.wa0; busA.WData0 = x.wd0;
    busA.We1 = x.we1; busA.WAddr1 = x.wa1; busA.WData1 = x.wd1;
    busA.FlagsMask = x.fm; busA.FlagsIn = x.fi;
    busA.ResvEn = x.re; busA.ResvAddr = x.ra; busA.RdAddr = {x.a1, x.a0};
    busB.We0 = x.we0; busB.WAddr0 = x.wa0; busB.WData0 = x.wd0;
    busB.We1 = x.we1; busB.WAddr1 = x.wa1; busB.WData1 = x.wd1;
    busB.FlagsMask = x.fm; busB.FlagsIn = x.fi;
    busB.ResvEn = x.re; busB.ResvAddr = x.ra; busB.RdAddr = {x.a1, x.a0};
  endtask
  task automatic checkAllZero(input string tag);
    check({tag, " A DebugData"}, 128'(busA.DebugData), 128'h0);
    check({tag, " A DebugBusy"}, 128'(busA.DebugBusy), 128'h0);
    check({tag, " A FlagsOut"}, 128'(busA.FlagsOut), 128'h0);
    check({tag, " A RdData"}, 128'(busA.RdData), 128'h0);
    check({tag, " A RdBusy"}, 128'(busA.RdBusy), 128'h0);
    check({tag, " B DebugData"}, 128'(busB.DebugData), 128'h0);
    check({tag, " B DebugBusy"}, 128'(busB.DebugBusy), 128'h0);
    check({tag, " B FlagsOut"}, 128'(busB.FlagsOut), 128'h0);
    check({tag, " B RdData"}, 128'(busB.RdData), 128'h0);
    check({tag, " B RdBusy"}, 128'(busB.RdBusy), 128'h0);
  endtask
  initial begin
    idle = '{default: '0};
    // we0 wa0 wd0 | we1 wa1 wd1 | fm fi | re ra | a0 a1 | A: rd0 rd1 busy | B: rd0 rd1 busy | flags
    v[0]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd3,3'd0, 16'h0000,16'h0000,2'b00, 16'h0000,16'h0000,2'b00, 16'h0000};
    v[1]  = '{1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd3,3'd0, 16'h0000,16'h0000,2'b00, 16'h1234,16'h0000,2'b00, 16'h0000};
    v[2]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd3,3'd2, 16'h1234,16'h0000,2'b00, 16'h1234,16'h0000,2'b00, 16'h0000};
    v[3]  = '{1'b1,3'd2,16'hAAAA, 1'b1,3'd2,16'h5555, 16'h0000,16'h0000, 1'b0,3'd0, 3'd2,3'd3, 16'h0000,16'h1234,2'b00, 16'h5555,16'h1234,2'b00, 16'h0000};
    v[4]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd2,3'd2, 16'h5555,16'h5555,2'b00, 16'h5555,16'h5555,2'b00, 16'h0000};
    v[5]  = '{1'b1,3'd7,16'h00F0, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd7,3'd2, 16'h0000,16'h5555,2'b00, 16'h00F0,16'h5555,2'b00, 16'h0000};
    v[6]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h000F,16'hFFFF, 1'b0,3'd0, 3'd7,3'd2, 16'h00F0,16'h5555,2'b00, 16'h00F0,16'h5555,2'b00, 16'h00F0};
    v[7]  = '{1'b1,3'd7,16'h1111, 1'b0,3'd0,16'h0000, 16'h000F,16'hFFFF, 1'b0,3'd0, 3'd7,3'd2, 16'h00FF,16'h5555,2'b00, 16'h1111,16'h5555,2'b00, 16'h00FF};
    v[8]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd7,3'd2, 16'h1111,16'h5555,2'b00, 16'h1111,16'h5555,2'b00, 16'h1111};
    v[9]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b1,3'd5, 3'd5,3'd4, 16'h0000,16'h0000,2'b00, 16'h0000,16'h0000,2'b00, 16'h1111};
    v[10] = '{1'b0,3'd0,16'h0000, 1'b1,3'd4,16'hBEEF, 16'h0000,16'h0000, 1'b0,3'd0, 3'd5,3'd4, 16'h0000,16'h0000,2'b01, 16'h0000,16'hBEEF,2'b01, 16'h1111};
    v[11] = '{1'b1,3'd5,16'h0042, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd5,3'd4, 16'h0000,16'hBEEF,2'b01, 16'h0042,16'hBEEF,2'b00, 16'h1111};
    v[12] = '{1'b1,3'd5,16'h0099, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b1,3'd5, 3'd5,3'd4, 16'h0042,16'hBEEF,2'b00, 16'h0099,16'hBEEF,2'b00, 16'h1111};
    v[13] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd5,3'd4, 16'h0099,16'hBEEF,2'b01, 16'h0099,16'hBEEF,2'b01, 16'h1111};
    v[14] = '{1'b1,3'd0,16'h7777, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b1,3'd0, 3'd0,3'd5, 16'h0000,16'h0099,2'b10, 16'h0000,16'h0099,2'b10, 16'h1111};
    v[15] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd0,3'd5, 16'h7777,16'h0099,2'b11, 16'h0000,16'h0099,2'b10, 16'h1111};
    v[16] = '{1'b0,3'd0,16'h0000, 1'b1,3'd5,16'h00AB, 16'h0000,16'h0000, 1'b0,3'd0, 3'd0,3'd5, 16'h7777,16'h0099,2'b11, 16'h0000,16'h00AB,2'b00, 16'h1111};
    v[17] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 16'h0000,16'h0000, 1'b0,3'd0, 3'd0,3'd5, 16'h7777,16'h00AB,2'b01, 16'h0000,16'h00AB,2'b00, 16'h1111};
    apply(idle);
    #12;
    checkAllZero("reset");
    @(negedge Clk);
    ResetN = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      apply(v[i]);
      #2;
      check($sformatf("v%0d A rd0", i), 128'(busA.RdData[15:0]), 128'(v[i].aRd0));
      check($sformatf("v%0d A rd1", i), 128'(busA.RdData[31:16]), 128'(v[i].aRd1));
      check($sformatf("v%0d A busy", i), 128'(busA.RdBusy), 128'(v[i].aBs));
      check($sformatf("v%0d A flags", i), 128'(busA.FlagsOut), 128'(v[i].fl));
      check($sformatf("v%0d B rd0", i), 128'(busB.RdData[15:0]), 128'(v[i].bRd0));
      check($sformatf("v%0d B rd1", i), 128'(busB.RdData[31:16]), 128'(v[i].bRd1));
      check($sformatf("v%0d B busy", i), 128'(busB.RdBusy), 128'(v[i].bBs));
      check($sformatf("v%0d B flags", i), 128'(busB.FlagsOut), 128'(v[i].fl));
    end
    check("A debug r3", 128'(busA.DebugData[3*16 +: 16]), 128'h1234);
    check("A debug r7", 128'(busA.DebugData[7*16 +: 16]), 128'h1111);
    check("A debug r0", 128'(busA.DebugData[15:0]), 128'h7777);
    check("A debug busy", 128'(busA.DebugBusy), 128'h01);
    check("B debug r0", 128'(busB.DebugData[15:0]), 128'h0);
    check("B debug r2", 128'(busB.DebugData[2*16 +: 16]), 128'h5555);
    check("B debug busy", 128'(busB.DebugBusy), 128'h00);
    @(negedge Clk);
    apply(idle);
    @(posedge Clk);
    #3;
    ResetN = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge Clk);
    ResetN = 1'b1;
    idle.we0 = 1'b1; idle.wa0 = 3'd1; idle.wd0 = 16'hCAFE; idle.a0 = 3'd1;
    apply(idle);
    #2;
    check("post-reset A pre", 128'(busA.RdData[15:0]), 128'h0);
    check("post-reset B bypass", 128'(busB.RdData[15:0]), 128'hCAFE);
    @(negedge Clk);
    idle.we0 = 1'b0;
    apply(idle);
    #2;
    check("post-reset A write", 128'(busA.RdData[15:0]), 128'hCAFE);
    check("post-reset B write", 128'(busB.DebugData[1*16 +: 16]), 128'hCAFE);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
